regfile_mp: RTL and testbench



---
 rtl/regfile_mp_if.sv | 30 +++
 rtl/regfile_mp.sv | 121 ++++++++++++
 tb/tb_regfile_mp.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module : regfile_mp_if -- read/write port bundle for regfile_mp
// Rev    : 1.0
// ============================================================================
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     ready;
  logic                     wr_conflict;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data, ready, wr_conflict
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data,
    output rd_data, ready, wr_conflict
  );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module : regfile_mp -- multi-port register file with sequential clear engine
//          Optional write-to-read forwarding: define REGFILE_BYPASS_EN
// Rev    : 1.0
// ============================================================================
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_mp_if.slave   bus_if
);

  localparam int DEPTH   = 2**ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              ready_q;
  logic              conflict_q, conflict_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [NUM_WR-1:0] wr_ok;

  // A write port is effective only when ready and not aimed at a hardwired zero.
  always_comb begin
    wr_ok = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      wr_ok[p] = ready_q && bus_if.wr_en[p] &&
                 !(ZERO_EN && (bus_if.wr_addr[p*ADDR_W +: ADDR_W] == '0));
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (&idx_q) state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    conflict_d = 1'b0;
    for (int a = 0; a < NUM_WR; a++) begin
      for (int b = a + 1; b < NUM_WR; b++) begin
        if (wr_ok[a] && wr_ok[b] &&
            (bus_if.wr_addr[a*ADDR_W +: ADDR_W] == bus_if.wr_addr[b*ADDR_W +: ADDR_W]))
          conflict_d = 1'b1;
      end
    end
  end

  // ready lags the move to RUN by one edge: DEPTH clear edges plus one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      idx_q      <= '0;
      ready_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ready_q    <= (state_q == ST_RUN);
      conflict_q <= conflict_d;
    end
  end

  // Ascending port order makes the highest-numbered port win on a shared address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem_q[idx_q] <= '0;
      end else begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (wr_ok[p])
            mem_q[bus_if.wr_addr[p*ADDR_W +: ADDR_W]] <= bus_if.wr_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] raddr_w;
    logic [DATA_W-1:0] rdata_w;

    assign raddr_w = bus_if.rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      rdata_w = mem_q[raddr_w];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_ok[p] && (bus_if.wr_addr[p*ADDR_W +: ADDR_W] == raddr_w))
          rdata_w = bus_if.wr_data[p*DATA_W +: DATA_W];
      end
`endif
      if (!ready_q || (ZERO_EN && (raddr_w == '0)))
        rdata_w = '0;
    end

    assign bus_if.rd_data[i*DATA_W +: DATA_W] = rdata_w;
  end : g_rd

  assign bus_if.ready       = ready_q;
  assign bus_if.wr_conflict = conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module : tb_regfile_mp -- directed scoreboard bench for regfile_mp
// Rev    : 1.0
// ============================================================================
module tb_regfile_mp;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_RD   = 2;
  localparam int NUM_WR   = 2;
  localparam int ZERO_REG = 1;
  localparam int DEPTH    = 2**ADDR_W;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

  regfile_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  typedef struct {
    string             tag;
    int                port;
    logic [DATA_W-1:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic read_push(input string tag, input int port, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] exp);
    bus.rd_addr[port*ADDR_W +: ADDR_W] = addr;
    sb.push_back('{tag, port, exp});
  endtask

  task automatic drain;
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, bus.rd_data[e.port*DATA_W +: DATA_W], e.exp);
    end
  endtask

  task automatic write(input int port, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    bus.wr_en[port]                    = 1'b1;
    bus.wr_addr[port*ADDR_W +: ADDR_W] = addr;
    bus.wr_data[port*DATA_W +: DATA_W] = data;
  endtask

  task automatic idle;
    bus.wr_en = '0;
  endtask

  initial begin
    bus.rd_addr = '0;
    bus.wr_en   = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;

    // Reset for two edges
    rst = 1'b1;
    tick;
    tick;
    check("reset_ready", {31'd0, bus.ready}, 32'd0);
    check("reset_conflict", {31'd0, bus.wr_conflict}, 32'd0);
    read_push("reset_rd", 0, 5'd3, 32'd0);
    drain;

    // Partial clear with writes attempted, then reset again at index 10
    rst = 1'b0;
    write(0, 5'd9, 32'h0000_0BAD);
    for (int k = 1; k <= 10; k++) begin
      tick;
      check("clear1_ready", {31'd0, bus.ready}, 32'd0);
      read_push("clear1_rd", 0, 5'd9, 32'd0);
      drain;
    end
    rst = 1'b1;
    tick;
    check("rerst_ready", {31'd0, bus.ready}, 32'd0);
    rst = 1'b0;
    idle;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      tick;
      check("clear2_ready", {31'd0, bus.ready}, (k == DEPTH + 1) ? 32'd1 : 32'd0);
    end

    // Every entry cleared
    for (int a = 0; a < DEPTH; a += 2) begin
      read_push("cleared", 0, 5'(a), 32'd0);
      read_push("cleared", 1, 5'(a + 1), 32'd0);
      drain;
    end

    // Basic dual write
    write(0, 5'd1, 32'h0000_00FA);
    write(1, 5'd2, 32'h0000_000B);
    tick;
    idle;
    check("basic_conflict", {31'd0, bus.wr_conflict}, 32'd0);
    read_push("basic_r1", 0, 5'd1, 32'h0000_00FA);
    read_push("basic_r2", 1, 5'd2, 32'h0000_000B);
    drain;

    // Same-address conflict: port1 wins, flag for one cycle
    write(0, 5'd5, 32'h11);
    write(1, 5'd5, 32'h22);
    tick;
    idle;
    check("conf_flag", {31'd0, bus.wr_conflict}, 32'd1);
    read_push("conf_r5", 0, 5'd5, 32'h22);
    drain;
    tick;
    check("conf_clear", {31'd0, bus.wr_conflict}, 32'd0);

    // Back-to-back conflicts keep the flag high
    write(0, 5'd6, 32'h33);
    write(1, 5'd6, 32'h44);
    tick;
    check("b2b_flag1", {31'd0, bus.wr_conflict}, 32'd1);
    write(0, 5'd8, 32'h1);
    write(1, 5'd8, 32'h2);
    tick;
    check("b2b_flag2", {31'd0, bus.wr_conflict}, 32'd1);
    idle;
    tick;
    check("b2b_clear", {31'd0, bus.wr_conflict}, 32'd0);
    read_push("b2b_r6", 0, 5'd6, 32'h44);
    read_push("b2b_r8", 1, 5'd8, 32'h2);
    drain;

    // Both ports on r0: only a conflict when r0 is an ordinary register
    write(0, 5'd0, 32'h1);
    write(1, 5'd0, 32'h2);
    tick;
    idle;
    check("zero_conflict", {31'd0, bus.wr_conflict}, (ZERO_REG != 0) ? 32'd0 : 32'd1);

    // Zero register
    write(0, 5'd0, 32'hDEAD_BEEF);
    tick;
    idle;
    read_push("zero_rd", 0, 5'd0, (ZERO_REG != 0) ? 32'd0 : 32'hDEAD_BEEF);
    drain;

    // Write-to-read in the same cycle
    write(0, 5'd7, 32'h55);
    tick;
    idle;
    write(1, 5'd7, 32'h1234);
    read_push("bypass_same", 0, 5'd7, BYPASS ? 32'h1234 : 32'h55);
    drain;
    tick;
    idle;
    read_push("bypass_after", 0, 5'd7, 32'h1234);
    drain;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
